// File: rtl/uc_multiciclo.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Optional UC_MC_ILLEGAL_TRAP_EN traps unsupported opcodes into an absorbing HALT state.
module uc_multiciclo (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  op,
   input  logic [2:0]  f3,
   input  logic        f7,
   input  logic        zero,
   output logic        pcWrite,
   output logic        adrSrc,
   output logic        memWrite,
   output logic        irWrite,
   output logic [1:0]  resSrc,
   output logic [1:0]  aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  immSrc,
   output logic [2:0]  aluControl,
   output logic        regWrite,
   output logic [31:0] instret
`ifdef UC_MC_ILLEGAL_TRAP_EN
  ,output logic        illegal
`endif
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
   } state_t;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

   state_t state, state_n;
   aluop_t aluop;
   logic   pcw, mw, irw, rw, retire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FETCH;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         FETCH:    state_n = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_R:         state_n = EXECUTER;
               OP_I:         state_n = EXECUTEI;
               OP_JAL:       state_n = JAL;
               OP_BEQ:       state_n = BEQ;
`ifdef UC_MC_ILLEGAL_TRAP_EN
               default:      state_n = HALT;
`else
               default:      state_n = FETCH;
`endif
            endcase
         end
         MEMADR:   state_n = (op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_n = MEMWB;
         EXECUTER, EXECUTEI, JAL: state_n = ALUWB;
         MEMWB, MEMWRITE, ALUWB, BEQ: state_n = FETCH;
         HALT:     state_n = HALT;
         default:  state_n = FETCH;
      endcase
   end

   always_comb begin
      pcw = 1'b0; adrSrc = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
      resSrc = 2'b00; aluSrcA = 2'b00; aluSrcB = 2'b00; aluop = ALU_ADD;
      case (state)
         FETCH:    begin irw = 1'b1; aluSrcB = 2'b10; resSrc = 2'b10; pcw = 1'b1; end
         DECODE:   begin aluSrcA = 2'b01; aluSrcB = 2'b01; end
         MEMADR:   begin aluSrcA = 2'b10; aluSrcB = 2'b01; end
         MEMREAD:  adrSrc = 1'b1;
         MEMWRITE: begin adrSrc = 1'b1; mw = 1'b1; end
         MEMWB:    begin resSrc = 2'b01; rw = 1'b1; end
         EXECUTER: begin aluSrcA = 2'b10; aluop = ALU_FUNCT; end
         EXECUTEI: begin aluSrcA = 2'b10; aluSrcB = 2'b01; aluop = ALU_FUNCT; end
         ALUWB:    rw = 1'b1;
         BEQ:      begin aluSrcA = 2'b10; aluop = ALU_SUB; pcw = zero; end
         JAL:      begin aluSrcA = 2'b01; aluSrcB = 2'b10; pcw = 1'b1; end
         default:  ;
      endcase
   end

   // write enables are killed combinationally so nothing commits while rst is low
   assign pcWrite  = rst & pcw;
   assign memWrite = rst & mw;
   assign irWrite  = rst & irw;
   assign regWrite = rst & rw;

   // op[5] separates R-type from I-type, so addi never subtracts
   always_comb begin
      aluControl = 3'b000;
      case (aluop)
         ALU_SUB:   aluControl = 3'b001;
         ALU_FUNCT: begin
            case (f3)
               3'b000:  aluControl = (op[5] & f7) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default:   aluControl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   immSrc = 2'b01;
         OP_BEQ:  immSrc = 2'b10;
         OP_JAL:  immSrc = 2'b11;
         default: immSrc = 2'b00;
      endcase
   end

   assign retire = (state == MEMWB) || (state == MEMWRITE) ||
                   (state == ALUWB) || (state == BEQ);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        instret <= '0;
      else if (retire) instret <= instret + 32'd1;
   end

`ifdef UC_MC_ILLEGAL_TRAP_EN
   assign illegal = (state == HALT);
`endif

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit for the RV32I core. A Moore state machine sequences a shared-memory datapath through fetch, decode, execute, memory and writeback, one step per clock, so a single unified memory and one ALU serve every phase of an instruction. It sits where the single-cycle control unit sits today. It is driven by the instruction register fields and the ALU `zero` flag, and it drives every datapath enable and mux select. A retired-instruction counter is included for bench and debug use.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- op  in  7  opcode, instr[6:0] from the instruction register
- f3  in  3  funct3, instr[14:12]
- f7  in  1  instr[30]
- zero  in  1  ALU zero flag
- pcWrite  out  1  PC register enable
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memWrite  out  1  memory write enable
- irWrite  out  1  instruction register and oldPC enable
- resSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- aluSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- aluControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- regWrite  out  1  register file write enable
- instret  out  32  count of retired instructions
- illegal  out  1  unsupported opcode trapped (present only with `UC_MC_ILLEGAL_TRAP_EN`)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, plus HALT when the macro is defined.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for op 0000011 or 0100011; →EXECUTER for 0110011; →EXECUTEI for 0010011; →JAL for 1101111; →BEQ for 1100011; any other opcode follows the Configuration rules.
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB. EXECUTER/EXECUTEI/JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ→FETCH.
- Moore outputs per state. Any signal not listed is 0.
  - FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=add, resSrc=10, pcWrite=1.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=add. This precomputes the branch target.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=add.
  - MEMREAD: adrSrc=1, resSrc=00.
  - MEMWRITE: adrSrc=1, resSrc=00, memWrite=1.
  - MEMWB: resSrc=01, regWrite=1.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=funct.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=funct.
  - ALUWB: resSrc=00, regWrite=1.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=sub, resSrc=00, pcWrite=zero.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=add, resSrc=00, pcWrite=1.
- aluControl:
  - aluOp=add gives 000; aluOp=sub gives 001.
  - aluOp=funct decodes f3:
    - f3=000: gives 001 when op[5]&f7, else 000. addi is never a subtract.
    - f3=010: 101. f3=110: 011. f3=111: 010. Any other f3: 000.
- immSrc: combinational from op in every state. sw→01, beq→10, jal→11, all others→00.
- instret: increments by 1 on each transition from MEMWB, MEMWRITE, ALUWB or BEQ to FETCH. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rst low): state←FETCH and instret←0, asynchronously.
  - While rst is low, pcWrite, irWrite, memWrite and regWrite are forced to 0.
  - All other outputs show their FETCH values.
- First FETCH edge is the first rising clk edge after rst deasserts.
- Cycles per instruction, FETCH inclusive: lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3, taken or not.
- BEQ: pcWrite follows `zero` combinationally in that state; zero is sampled at the same edge as the state change.
- rst asserted mid-instruction: the state is abandoned immediately. No partial write may occur after rst falls.
- Next state depends only on state and op, and op is stable because irWrite=1 only in FETCH.

## Configuration
- `UC_MC_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode in DECODE goes to HALT. HALT is absorbing until reset.
  - In HALT, illegal=1, all write enables are 0, and instret is frozen.
- Not defined:
  - An unsupported opcode in DECODE returns to FETCH as a NOP. instret is not incremented, and the next PC is PC+4.
  - The illegal port does not exist.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release. Expect pcWrite=irWrite=0 during reset, instret=0, and FETCH outputs with pcWrite=1 on the first cycle after release.
- lw then sw with op 0000011 then 0100011: expect state sequences of 5 and 4 cycles, memWrite=1 only in the 4th cycle of sw, regWrite=1 only in the 5th cycle of lw, and instret=2.
- R-type sub (f3=000, f7=1) and addi (f3=000, f7=1): expect aluControl=001 in EXECUTER and 000 in EXECUTEI.
- beq with zero=1 then zero=0: expect pcWrite=1 and then 0 in the BEQ state, 3 cycles each, with instret incremented on both.
- jal: expect the sequence FETCH, DECODE, JAL, ALUWB, with pcWrite=1 in JAL, regWrite=1 in ALUWB and immSrc=11 throughout.
- Opcode 1110011, and rst pulsed low during MEMWRITE:
  - With `UC_MC_ILLEGAL_TRAP_EN` defined: HALT with illegal=1 and instret unchanged for 10 cycles.
  - Without it: returns to FETCH after 2 cycles.
  - The rst pulse during MEMWRITE drops memWrite to 0 immediately.
